// File: rtl/ping_pong_input_buffer.sv
// ping_pong_input_buffer
// Two-bank sample buffer: the source fills one bank while the consumer
// drains the other. A bank is only presented downstream once it holds a
// complete frame of DEPTH samples. buffer_toggle names the bank being
// drained so the consumer can see frame boundaries.
module ping_pong_input_buffer #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_input,
    output logic              data_valid,
    input  logic              data_ack,
    output logic              buffer_toggle,
    output logic [7:0]        overflow_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [7:0] OVF_MAX = 8'hFF;

    // Sample storage: two banks of DEPTH registers.
    logic [DATA_W-1:0] mem [2][DEPTH];

    // Per-bank "holds a complete, not yet fully drained frame" flags.
    logic [1:0] full;

    // Write side.
    logic             wr_bank;
    logic [IDX_W-1:0] wr_idx;

    // Read side; rd_bank is exported as buffer_toggle.
    logic             rd_bank;
    logic [IDX_W-1:0] rd_idx;

    // Handshake decode.
    logic wr_accept;
    logic wr_reject;
    logic wr_last;
    logic rd_accept;
    logic rd_last;

    // Per-bank set/clear requests for the full flags.
    logic [1:0] full_set;
    logic [1:0] full_clr;

    assign in_ready   = ~full[wr_bank];
    assign data_valid = full[rd_bank];
    assign data_input = mem[rd_bank][rd_idx];

    assign buffer_toggle = rd_bank;

    assign wr_accept = in_valid & in_ready;
    assign wr_reject = in_valid & ~in_ready;
    assign wr_last   = (wr_idx == LAST_IDX);
    assign rd_accept = data_valid & data_ack;
    assign rd_last   = (rd_idx == LAST_IDX);

    // A bank becomes full on its DEPTH-th write and empties on its DEPTH-th
    // ack. Because a full bank is never written and an unfull bank is never
    // read, a set and a clear in the same cycle always hit different banks.
    always_comb begin
        full_set = 2'b00;
        full_clr = 2'b00;
        for (int b = 0; b < 2; b++) begin
            if (wr_accept && wr_last && (wr_bank == b[0])) begin
                full_set[b] = 1'b1;
            end
            if (rd_accept && rd_last && (rd_bank == b[0])) begin
                full_clr[b] = 1'b1;
            end
        end
    end

    // Bank full flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 2'b00;
        end else begin
            full <= (full | full_set) & ~full_clr;
        end
    end

    // Sample registers: cleared on reset so a discarded frame never leaks out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem[b][e] <= '0;
                end
            end
        end else if (wr_accept) begin
            mem[wr_bank][wr_idx] <= in_data;
        end
    end

    // Write pointer: walk the bank, then hop to the other bank at frame end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else if (wr_accept) begin
            if (wr_last) begin
                wr_bank <= ~wr_bank;
                wr_idx  <= '0;
            end else begin
                wr_idx <= wr_idx + 1'b1;
            end
        end
    end

    // Read pointer: acks while nothing is valid are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_bank <= 1'b0;
            rd_idx  <= '0;
        end else if (rd_accept) begin
            if (rd_last) begin
                rd_bank <= ~rd_bank;
                rd_idx  <= '0;
            end else begin
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

    // Saturating count of cycles where a sample was offered but refused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_count <= 8'h00;
        end else if (wr_reject && (overflow_count != OVF_MAX)) begin
            overflow_count <= overflow_count + 8'h01;
        end
    end

endmodule

// File: doc/ping_pong_input_buffer.md
# ping_pong_input_buffer

Double-banked (ping-pong) byte buffer that sits directly upstream of the isolation-tree state machine. A sample source writes bytes into one bank while the downstream anomaly checker drains the other. A bank is released downstream only once it holds a complete frame of DEPTH samples. `buffer_toggle` identifies the bank being drained, so the consumer can detect bank switches.

## Interface
- DEPTH, 8, samples per bank; power of two, 2..256
- DATA_W, 8, sample width in bits
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in_data  input  DATA_W  sample from source
- in_valid  input  1  in_data valid this cycle
- in_ready  output  1  buffer can accept a sample this cycle
- data_input  output  DATA_W  sample presented to consumer
- data_valid  output  1  data_input valid (a full bank is being drained)
- data_ack  input  1  consumer has taken data_input this cycle
- buffer_toggle  output  1  index of the bank currently being drained
- overflow_count  output  8  saturating count of rejected input cycles

## Operation
- Storage: 2 × DEPTH flop registers, all cleared on reset.
- Per-bank `full[1:0]` flags. Write-side state: wr_bank, wr_idx (log2 DEPTH bits). Read-side state: rd_bank (= buffer_toggle), rd_idx.
- `in_ready = !full[wr_bank]`.
- Write accepted when in_valid && in_ready:
  - store to bank[wr_bank][wr_idx].
  - If wr_idx == DEPTH-1: set full[wr_bank], flip wr_bank, wr_idx ← 0. Otherwise wr_idx++.
- Reject when in_valid && !in_ready:
  - sample dropped.
  - overflow_count increments, saturating at 255.
- `data_valid = full[rd_bank]`. `data_input = bank[rd_bank][rd_idx]` (combinational read of registers).
- Read accepted when data_valid && data_ack:
  - If rd_idx == DEPTH-1: clear full[rd_bank], flip rd_bank (buffer_toggle toggles), rd_idx ← 0. Otherwise rd_idx++.
- data_ack while !data_valid is ignored; no state change.
- Per-bank states: EMPTY → FILLING (first write) → FULL (DEPTH-th write) → DRAINING (first ack) → EMPTY (DEPTH-th ack). Banks alternate strictly: bank 0 first, then bank 1, then bank 0.
- Invariant: a bank is never written while full, and never read while not full.
  - Therefore a full-set on the write bank and a full-clear on the read bank in the same cycle always target different banks. Both take effect.
- Both banks full: in_ready = 0 until the read bank fully drains. in_ready returns 1 in the cycle after the final ack.
- Reset (any time, including mid-fill or mid-drain): all frame contents discarded, no partial frame is emitted, and all counters clear.

## Timing
- Reset values:
  - in_ready = 1, data_valid = 0, data_input = 0, buffer_toggle = 0, overflow_count = 0.
  - Internal: wr_bank = 0, wr_idx = 0, rd_idx = 0, full = 2'b00.
- Fill-to-valid latency: data_valid rises in the cycle after the clock edge that accepts the DEPTH-th write of a bank.
- Drain throughput: 1 sample per cycle with data_ack held high. The next sample appears on data_input the cycle after each ack.
- buffer_toggle and data_valid update in the cycle after the final ack of a bank.
  - If the other bank is already full, data_valid stays 1 without a gap and data_input shows the new bank's sample 0.
- Sustained rate: continuous writes at 1/cycle with continuous acks never stall. in_ready stays 1.

## Test plan
- Reset, then write 0x01..0x04 (DEPTH=4) on consecutive cycles:
  - data_valid = 0 through the 4th write edge, then 1.
  - data_input = 0x01, buffer_toggle = 0.
- Same setup, then hold data_ack = 1 for 4 cycles:
  - data_input sequence is 0x01, 0x02, 0x03, 0x04.
  - Next cycle: data_valid = 0, buffer_toggle = 1.
- Write 8 samples 0x10..0x17 with no acks:
  - in_ready = 0 after the 8th write.
  - 3 further in_valid cycles give overflow_count = 3.
  - Drain bank 0 (4 acks): in_ready = 1, buffer_toggle = 1, data_valid still 1, data_input = 0x14.
- Continuous writes and continuous acks for 64 samples:
  - in_ready never drops.
  - Output order equals input order; buffer_toggle flips every 4 acks.
- Assert reset after 2 of 4 writes of bank 1, with bank 0 mid-drain:
  - All outputs return to reset values.
  - A fresh 4-sample fill produces its data on bank 0.
- Hold in_valid = 1 with both banks full for 300 cycles: overflow_count saturates at 255.
